fpmul_arbiter: RTL and testbench
================================

# fpmul_arbiter

Two-requester scheduler that shares one pipelined single-precision multiplier (the FPmul with output register) between two operand sources. It accepts operand pairs over valid/ready handshakes and issues at most one pair per cycle to the multiplier. A tag pipeline tracks which requester owns each in-flight operation, and each result is routed back to its owner's response port. It sits between the operand producers and the multiplier instance, replacing the direct data-maker-to-multiplier connection.

## Interface
- LAT, 4, multiplier latency: cycles from operands visible on MUL_A/MUL_B to the matching product valid on MUL_Z; legal range 1..16
- CLK in 1: single clock, rising edge
- RST_n in 1: asynchronous, active-low reset
- REQ0_VALID in 1: requester 0 has an operand pair
- REQ0_A, REQ0_B in 32: requester 0 operands, IEEE-754 single
- REQ0_READY out 1: requester 0 accepted this cycle
- REQ1_VALID, REQ1_A, REQ1_B, REQ1_READY: same signals for requester 1
- HALT in 1: blocks new issues; in-flight operations keep draining
- MUL_A, MUL_B out 32: registered operands to the multiplier FP_A/FP_B
- MUL_Z in 32: multiplier FP_Z
- RSP0_VALID out 1, RSP0_Z out 32: requester 0 result, one-cycle pulse
- RSP1_VALID out 1, RSP1_Z out 32: requester 1 result
- BUSY out 1: at least one operation is in flight

## Operation
- Handshake: a transfer occurs on a rising edge where REQx_VALID and REQx_READY are both high. READY is combinational from the VALIDs, HALT and the priority pointer. At most one READY is high per cycle. READY is low whenever HALT=1.
- Grant with one requester valid: that requester is granted.
- Grant with both requesters valid: the requester selected by the priority pointer PRIO is granted (see Configuration).
- Issue: on a transfer edge, MUL_A/MUL_B capture the granted operands and a tag {valid=1, id} enters the tag pipeline.
- No transfer: MUL_A/MUL_B hold their values, and an invalid tag enters the pipeline.
- Tag pipeline: LAT stages. The output stage is aligned with the MUL_Z that belongs to it.
- Tag output valid: on that edge, RSP[id]_Z captures MUL_Z and RSP[id]_VALID is set. The other response port's VALID is cleared and its Z holds.
- Tag output invalid: both VALIDs are cleared and both Z values hold.
- Responses have no backpressure; each sink must accept every pulse.
- BUSY is the OR of all tag-pipeline valid bits.
- Back-to-back issue is allowed every cycle. Throughput is 1 operation per cycle.
- Products are passed through bit-exact; the block does no arithmetic.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - MUL_A=MUL_B=0
  - RSP0/1_VALID=0, RSP0/1_Z=0
  - all tags invalid, BUSY=0
  - PRIO=requester 0
- End-to-end latency: handshake on edge t → operands visible on MUL_A/B in cycle t+1 → MUL_Z valid in cycle t+1+LAT → RSPx_VALID high in cycle t+2+LAT, for exactly one cycle.
- Responses per requester return in issue order.
- Reset mid-operation: all in-flight tags are dropped and no responses are produced for them. The first accept is possible on the first edge after deassertion.
- HALT asserted while both requesters are valid: no grant and PRIO unchanged. BUSY falls LAT+1 edges after the last issue.
- HALT deasserted: a grant is possible in the same cycle.

## Configuration
- FPMUL_ARB_RR_EN defined: round-robin arbitration. After every transfer, PRIO points to the requester that was not granted. With both valid continuously, grants alternate 0,1,0,1…
- FPMUL_ARB_RR_EN undefined: fixed priority, requester 0 always wins. PRIO logic is removed and requester 1 can starve.

## Structure
- Package fpmul_arb_pkg:
  - WORD_W=32
  - N_REQ=2
  - LAT_MAX=16
  - tag struct {logic valid; logic id}
- Sub-module fpmul_arb_tagpipe: parameterised LAT-stage shift register of tags with asynchronous active-low clear. It exposes the output-stage tag and an any-valid flag.
- Arbiter logic, operand registers and response registers stay in fpmul_arbiter.

## Test plan
- Single op: REQ0 sends A=0x40400000 (3.0), B=0x40000000 (2.0) on edge t → RSP0_VALID in cycle t+6 (LAT=4) with RSP0_Z=0x40C00000; RSP1_VALID stays 0.
- Contention (RR_EN defined): both valid for 4 cycles → grants 0,1,0,1. Responses alternate on consecutive cycles, e.g. REQ1 1.5×1.5 returns RSP1_Z=0x40100000.
- Contention (RR_EN undefined): both valid for 4 cycles → four REQ0 grants, REQ1_READY stays 0.
- HALT: assert HALT with both requesters valid for 3 cycles → READYs stay 0, PRIO held, in-flight results still delivered, BUSY drops after the pipeline drains.
- Reset mid-flight: issue 3 ops, assert RST_n=0 two cycles later → all outputs 0 immediately, no RSP pulses after release.
- Streaming: REQ0 issues 20 back-to-back products → 20 consecutive RSP0 pulses in order, bit-exact against a reference model.

Source files
------------

// File: rtl/fpmul_arb_pkg.sv
// Shared types and constants for the fpmul_arbiter slice: word width,
// requester count, latency bound and the in-flight tag record.
package fpmul_arb_pkg;

  localparam int WORD_W  = 32;
  localparam int N_REQ   = 2;
  localparam int LAT_MAX = 16;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  function automatic tag_t make_tag(input logic valid, input logic id);
    tag_t t;
    t.valid = valid;
    t.id    = id;
    return t;
  endfunction

endpackage

// File: rtl/fpmul_arb_tagpipe.sv
// LAT-stage shift register of ownership tags, kept in step with the multiplier
// pipeline; exposes the output-stage tag and an any-stage-valid flag.
module fpmul_arb_tagpipe
  import fpmul_arb_pkg::*;
#(
  parameter int LAT = 4
)
(
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic any_valid_o
);

  tag_t stage_q [LAT];
  tag_t stage_d [LAT];

  always_comb begin
    stage_d[0] = tag_i;
    for (int i = 1; i < LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= make_tag(1'b0, 1'b0);
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      any_valid_o = any_valid_o | stage_q[i].valid;
    end
  end

  assign tag_o = stage_q[LAT-1];

endmodule

// File: rtl/fpmul_arbiter.sv
// Two-requester front end sharing one pipelined FP multiplier; results are
// routed back by tag. Define FPMUL_ARB_RR_EN for round-robin, else requester 0 wins.
module fpmul_arbiter
  import fpmul_arb_pkg::*;
#(
  parameter int LAT = 4
)
(
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              REQ0_VALID,
  input  logic [WORD_W-1:0] REQ0_A,
  input  logic [WORD_W-1:0] REQ0_B,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic [WORD_W-1:0] REQ1_A,
  input  logic [WORD_W-1:0] REQ1_B,
  output logic              REQ1_READY,
  input  logic              HALT,
  output logic [WORD_W-1:0] MUL_A,
  output logic [WORD_W-1:0] MUL_B,
  input  logic [WORD_W-1:0] MUL_Z,
  output logic              RSP0_VALID,
  output logic [WORD_W-1:0] RSP0_Z,
  output logic              RSP1_VALID,
  output logic [WORD_W-1:0] RSP1_Z,
  output logic              BUSY
);

  if (LAT < 1 || LAT > LAT_MAX) begin : g_bad_lat
    $error("fpmul_arbiter: LAT out of range 1..16");
  end

  logic              gnt0_s, gnt1_s, prio_s;
  logic [WORD_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  tag_t              issue_q, issue_d, tag_out_s;
  logic              pipe_busy_s;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0] rsp_z_q [N_REQ];
  logic [WORD_W-1:0] rsp_z_d [N_REQ];

`ifdef FPMUL_ARB_RR_EN
  logic prio_q, prio_d;

  // After each transfer the requester that lost gets priority next time.
  always_comb begin
    prio_d = prio_q;
    if (gnt0_s) begin
      prio_d = 1'b1;
    end else if (gnt1_s) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio_s = prio_q;
`else
  assign prio_s = 1'b0;
`endif

  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (HALT) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (REQ0_VALID && (!REQ1_VALID || !prio_s)) begin
      gnt0_s = 1'b1;
    end else if (REQ1_VALID) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign REQ0_READY = gnt0_s;
  assign REQ1_READY = gnt1_s;

  // Operands hold when idle so the multiplier input stays quiet.
  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    issue_d = make_tag(1'b0, 1'b0);
    if (gnt0_s) begin
      mul_a_d = REQ0_A;
      mul_b_d = REQ0_B;
      issue_d = make_tag(1'b1, 1'b0);
    end else if (gnt1_s) begin
      mul_a_d = REQ1_A;
      mul_b_d = REQ1_B;
      issue_d = make_tag(1'b1, 1'b1);
    end else begin
      issue_d = make_tag(1'b0, 1'b0);
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      issue_q <= make_tag(1'b0, 1'b0);
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      issue_q <= issue_d;
    end
  end

  // issue_q sits beside MUL_A/B, so LAT further stages line up with MUL_Z.
  fpmul_arb_tagpipe #(.LAT(LAT)) u_tagpipe (
    .clk_i       (CLK),
    .rst_ni      (RST_n),
    .tag_i       (issue_q),
    .tag_o       (tag_out_s),
    .any_valid_o (pipe_busy_s)
  );

  always_comb begin
    rsp_valid_d = '0;
    rsp_z_d     = rsp_z_q;
    if (tag_out_s.valid) begin
      rsp_valid_d[tag_out_s.id] = 1'b1;
      rsp_z_d[tag_out_s.id]     = MUL_Z;
    end else begin
      rsp_valid_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rsp_valid_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_z_q[i] <= '0;
      end
    end else begin
      rsp_valid_q <= rsp_valid_d;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_z_q[i] <= rsp_z_d[i];
      end
    end
  end

  assign MUL_A      = mul_a_q;
  assign MUL_B      = mul_b_q;
  assign RSP0_VALID = rsp_valid_q[0];
  assign RSP1_VALID = rsp_valid_q[1];
  assign RSP0_Z     = rsp_z_q[0];
  assign RSP1_Z     = rsp_z_q[1];
  assign BUSY       = issue_q.valid | pipe_busy_s;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter with a LAT-cycle multiplier stand-in;
// expectations follow FPMUL_ARB_RR_EN the same way the design does.
module tb_fpmul_arbiter;

  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY, HALT;
  logic [31:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [31:0] MUL_A, MUL_B, MUL_Z;
  logic        RSP0_VALID, RSP1_VALID, BUSY;
  logic [31:0] RSP0_Z, RSP1_Z;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        id;
    logic [31:0] z;
    int          due;
  } exp_t;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
  } vec_t;

  exp_t        exp_q [$];
  exp_t        e_m;
  logic        id_m;
  logic [31:0] hold_z [2];
  logic        exp_prio;
  logic [31:0] zp [LAT];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  fpmul_arbiter #(.LAT(LAT)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .REQ0_VALID(REQ0_VALID), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_READY(REQ1_READY),
    .HALT(HALT), .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_Z(MUL_Z),
    .RSP0_VALID(RSP0_VALID), .RSP0_Z(RSP0_Z),
    .RSP1_VALID(RSP1_VALID), .RSP1_Z(RSP1_Z), .BUSY(BUSY)
  );

  // Multiplier stand-in: exact IEEE products for the directed operands,
  // integer product otherwise (the arbiter only passes bits through).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000) return b;
    if (b == 32'h3F800000) return a;
    if (a == 32'h40400000 && b == 32'h40000000) return 32'h40C00000;
    if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
    if (a == 32'hC0000000 && b == 32'h40400000) return 32'hC0C00000;
    if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    return a * b;
  endfunction

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < LAT; i++) zp[i] <= 32'h0;
    end else begin
      zp[0] <= fmul(MUL_A, MUL_B);
      for (int i = 1; i < LAT; i++) zp[i] <= zp[i-1];
    end
  end
  assign MUL_Z = zp[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response scoreboard: order, owner, value, arrival cycle and hold of the idle port.
  always @(negedge CLK) begin
    if (RST_n) begin
      if (RSP0_VALID && RSP1_VALID) begin
        chk("rsp_both", 32'd1, 32'd0);
      end else if (RSP0_VALID || RSP1_VALID) begin
        id_m = RSP1_VALID;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e_m = exp_q.pop_front();
          chk("rsp_id", {31'd0, id_m}, {31'd0, e_m.id});
          chk("rsp_z", id_m ? RSP1_Z : RSP0_Z, e_m.z);
          chk("rsp_cycle", cyc, e_m.due);
          chk("rsp_hold", id_m ? RSP0_Z : RSP1_Z, hold_z[!id_m]);
          hold_z[id_m] = e_m.z;
        end
      end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
        e_m = exp_q.pop_front();
        chk("rsp_missing", 32'd0, e_m.z);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One request cycle: drive, check READY against the spec's grant rule, record expectations.
  task automatic cycle_req(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] z0, input logic v1, input logic [31:0] a1,
                           input logic [31:0] b1, input logic [31:0] z1);
    logic e0, e1;
    exp_t x;
    REQ0_VALID = v0; REQ0_A = a0; REQ0_B = b0;
    REQ1_VALID = v1; REQ1_A = a1; REQ1_B = b1;
    e0 = !HALT && v0 && (!v1 || !exp_prio);
    e1 = !HALT && v1 && !e0;
    #1;
    chk("ready0", {31'd0, REQ0_READY}, {31'd0, e0});
    chk("ready1", {31'd0, REQ1_READY}, {31'd0, e1});
    if (e0 || e1) begin
      x.id = e1; x.z = e1 ? z1 : z0; x.due = cyc + LAT + 2;
      exp_q.push_back(x);
    end
`ifdef FPMUL_ARB_RR_EN
    if (e0) exp_prio = 1'b1;
    else if (e1) exp_prio = 1'b0;
`endif
    @(posedge CLK);
    #1;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b0, 32'h40400000, 32'h40000000, 32'h40C00000};
    vecs[1] = '{1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
    vecs[2] = '{1'b0, 32'h40000000, 32'h40000000, 32'h40800000};
    vecs[3] = '{1'b1, 32'hC0000000, 32'h40400000, 32'hC0C00000};
    vecs[4] = '{1'b1, 32'h3F800000, 32'h40490FDB, 32'h40490FDB};
    vecs[5] = '{1'b0, 32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF};

    RST_n = 1'b0; HALT = 1'b0; exp_prio = 1'b0;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    REQ0_A = 32'h0; REQ0_B = 32'h0; REQ1_A = 32'h0; REQ1_B = 32'h0;
    hold_z[0] = 32'h0; hold_z[1] = 32'h0;
    tick(); tick();
    chk("rst_mul_a", MUL_A, 32'h0);
    chk("rst_mul_b", MUL_B, 32'h0);
    chk("rst_rsp_valid", {30'd0, RSP1_VALID, RSP0_VALID}, 32'h0);
    chk("rst_rsp0_z", RSP0_Z, 32'h0);
    chk("rst_rsp1_z", RSP1_Z, 32'h0);
    chk("rst_busy", {31'd0, BUSY}, 32'h0);
    RST_n = 1'b1;
    tick();

    // Isolated operations, one at a time; latency and data checked by the scoreboard.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].id) cycle_req(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].z);
      else            cycle_req(1'b1, vecs[i].a, vecs[i].b, vecs[i].z, 1'b0, 32'h0, 32'h0, 32'h0);
      chk("issue_mul_a", MUL_A, vecs[i].a);
      chk("issue_mul_b", MUL_B, vecs[i].b);
      idle(LAT + 3);
    end

    // HALT with both valid: no grants, priority held, in-flight op still delivered.
    cycle_req(1'b1, 32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 32'h0, 32'h0, 32'h0);
    HALT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle_req(1'b1, 32'h40000000, 32'h40000000, 32'h40800000,
                1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
      chk("halt_busy", {31'd0, BUSY}, 32'd1);
    end
    HALT = 1'b0;
    cycle_req(1'b1, 32'h40000000, 32'h40000000, 32'h40800000,
              1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    chk("busy_after_issue", {31'd0, BUSY}, 32'd1);
    for (int i = 0; i < LAT; i++) tick();
    chk("busy_last_stage", {31'd0, BUSY}, 32'd1);
    tick();
    chk("busy_drained", {31'd0, BUSY}, 32'd0);
    idle(4);

    // Reset mid-flight: three ops dropped, no responses afterwards.
    for (int i = 0; i < 3; i++)
      cycle_req(1'b1, 32'h00000100 + i, 32'h3, 32'h300 + 3 * i, 1'b0, 32'h0, 32'h0, 32'h0);
    idle(2);
    RST_n = 1'b0;
    exp_q.delete();
    hold_z[0] = 32'h0; hold_z[1] = 32'h0; exp_prio = 1'b0;
    #1;
    chk("midrst_mul_a", MUL_A, 32'h0);
    chk("midrst_busy", {31'd0, BUSY}, 32'h0);
    chk("midrst_rsp0_z", RSP0_Z, 32'h0);
    chk("midrst_rsp1_z", RSP1_Z, 32'h0);
    tick(); tick();
    RST_n = 1'b1;
    cycle_req(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h3F800000, 32'h12345678, 32'h12345678);
    idle(LAT + 6);

    // Contention for four cycles starting from priority 0.
    for (int i = 0; i < 4; i++)
      cycle_req(1'b1, 32'h40400000, 32'h40000000, 32'h40C00000,
                1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    idle(LAT + 4);

    // Streaming: 20 back-to-back products from requester 0.
    for (int i = 0; i < 20; i++)
      cycle_req(1'b1, 32'h00001000 + i, 32'h00000003 + i,
                (32'h00001000 + i) * (32'h00000003 + i), 1'b0, 32'h0, 32'h0, 32'h0);
    idle(LAT + 6);

    chk("drain_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
